// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
//   Elastic pipeline-stage buffer. It holds up to DEPTH payload entries in
//   order and uses a valid/ready handshake on both sides. A flush empties the
//   stage, so the stage presents the RESET_VAL bubble downstream. With
//   DEPTH=1 it behaves as a classic stall/flush pipeline register.
//
// Parameters
//   WIDTH      payload bits per entry
//   DEPTH      number of entries, legal range 1..4
//   RESET_VAL  value driven on out_data when the stage is empty
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous reset, active low (the stage is in reset when 0)
//   flush      discards all held entries and the current input beat
//   in_valid   upstream offers in_data
//   in_ready   the buffer accepts in_data this cycle
//   in_data    upstream payload
//   out_valid  the head entry is valid
//   out_ready  downstream consumes the head this cycle
//   out_data   head payload, or RESET_VAL when out_valid is 0
//   count      number of occupied entries
//
// Optional build macro: PIPE_STAGE_BUF_PERF_EN
//   When it is defined, the block adds three saturating performance counters:
//   stall_cnt, flush_cnt and full_cnt.
// -----------------------------------------------------------------------------
module pipe_stage_buf #(
    parameter int               WIDTH     = 205,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef PIPE_STAGE_BUF_PERF_EN
    ,
    output logic [31:0]                stall_cnt,
    output logic [15:0]                flush_cnt,
    output logic [31:0]                full_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    // A single-entry buffer still needs a 1-bit pointer. That pointer always stays at 0.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push;
    logic pop;
    logic mem_we;

    // in_ready comes combinationally from out_ready. A full buffer that is
    // being drained can therefore still accept a beat in the same cycle.
    assign in_ready  = (count_q < DEPTH_C) | out_ready;
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem[rd_ptr_q] : RESET_VAL;
    assign count     = count_q;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;
    // While reset is asserted, in_ready can still read 1, but no beat lands in storage.
    assign mem_we = push & reset;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (!reset || flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is not reset. Only the pointers and count track validity.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (mem_we && (wr_ptr_q == PTR_W'(gi))) begin
                    mem[gi] <= in_data;
                end
            end
        end
    endgenerate

`ifdef PIPE_STAGE_BUF_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] full_cnt_q,  full_cnt_d;

    // Each counter saturates: it stops incrementing once every bit is set.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        full_cnt_d  = full_cnt_q;
        if (in_valid && !in_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
        if ((count_q == DEPTH_C) && (full_cnt_q != '1)) begin
            full_cnt_d = full_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            full_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            full_cnt_q  <= full_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign full_cnt  = full_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buf
//   Directed bench for pipe_stage_buf. It uses one DEPTH=2 instance and one
//   DEPTH=3 instance, each with a 16-bit payload and a non-zero RESET_VAL.
//   A non-zero RESET_VAL makes the empty-stage bubble distinguishable from
//   real data.
//   Inputs are driven 1 time unit after the rising edge. Outputs are sampled
//   1 time unit after that, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buf;

    localparam logic [15:0] RV = 16'hDEAD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        iv;
    logic        irdy;
    logic [15:0] id;
    logic        ov;
    logic        ordy;
    logic [15:0] od;
    logic [1:0]  cnt;

    logic        iv3;
    logic        irdy3;
    logic [15:0] id3;
    logic        ov3;
    logic        ordy3;
    logic [15:0] od3;
    logic [1:0]  cnt3;

`ifdef PIPE_STAGE_BUF_PERF_EN
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [31:0] full_cnt;
    logic [31:0] stall_cnt3;
    logic [15:0] flush_cnt3;
    logic [31:0] full_cnt3;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.WIDTH(16), .DEPTH(2), .RESET_VAL(RV)) u_dut2 (
        .clk       (clk),
        .reset     (rst_n),
        .flush     (flush),
        .in_valid  (iv),
        .in_ready  (irdy),
        .in_data   (id),
        .out_valid (ov),
        .out_ready (ordy),
        .out_data  (od),
        .count     (cnt)
`ifdef PIPE_STAGE_BUF_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
        .full_cnt  (full_cnt)
`endif
    );

    pipe_stage_buf #(.WIDTH(16), .DEPTH(3), .RESET_VAL(RV)) u_dut3 (
        .clk       (clk),
        .reset     (rst_n),
        .flush     (1'b0),
        .in_valid  (iv3),
        .in_ready  (irdy3),
        .in_data   (id3),
        .out_valid (ov3),
        .out_ready (ordy3),
        .out_data  (od3),
        .count     (cnt3)
`ifdef PIPE_STAGE_BUF_PERF_EN
        ,
        .stall_cnt (stall_cnt3),
        .flush_cnt (flush_cnt3),
        .full_cnt  (full_cnt3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
            $display("[TB] ok   %-14s got=%0h", tag, got);
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [15:0] q[$];
        int          mcount;
        int          pushes;
        int          pops;
        int          cyc;
        logic        m_push;
        logic        m_pop;
        logic [15:0] iv_pat;
        logic [15:0] or_pat;

        rst_n = 1'b0; flush = 1'b0; iv = 1'b0; id = '0; ordy = 1'b0;
        iv3 = 1'b0; id3 = '0; ordy3 = 1'b0;
        tick(); tick();
        #1;
        chk("rst_cnt",   32'(cnt), 32'd0);
        chk("rst_ov",    32'(ov),  32'd0);
        chk("rst_od",    32'(od),  32'(RV));
        rst_n = 1'b1;
        tick();

        // --- stream 1,2,3 with out_ready=1 ---
        ordy = 1'b1; iv = 1'b1; id = 16'd1;
        #1 chk("s_irdy0", 32'(irdy), 32'd1);
        tick(); id = 16'd2;
        #1 chk("s_od1",   32'(od),   32'd1);
        chk("s_cnt1",  32'(cnt),  32'd1);
        chk("s_irdy1", 32'(irdy), 32'd1);
        tick(); id = 16'd3;
        #1 chk("s_od2",   32'(od),   32'd2);
        chk("s_cnt2",  32'(cnt),  32'd1);
        tick(); iv = 1'b0;
        #1 chk("s_od3",   32'(od),   32'd3);
        chk("s_cnt3",  32'(cnt),  32'd1);
        tick();
        #1 chk("s_empty_ov", 32'(ov), 32'd0);
        chk("s_empty_od", 32'(od), 32'(RV));

        // --- back-pressure: fill A,B then offer C ---
        ordy = 1'b0; iv = 1'b1; id = 16'hA;
        tick(); id = 16'hB;
        tick(); id = 16'hC;
        #1 chk("bp_cnt_full", 32'(cnt),  32'd2);
        chk("bp_irdy0",    32'(irdy), 32'd0);
        chk("bp_head_a",   32'(od),   32'hA);
        tick();
        #1 chk("bp_hold_cnt", 32'(cnt), 32'd2);
        chk("bp_hold_od",  32'(od),  32'hA);
        ordy = 1'b1;
        #1 chk("bp_irdy_drain", 32'(irdy), 32'd1);
        tick(); iv = 1'b0;
        #1 chk("bp_od_b",  32'(od),  32'hB);
        chk("bp_cnt_pp", 32'(cnt), 32'd2);
        tick();
        #1 chk("bp_od_c",  32'(od),  32'hC);
        chk("bp_cnt1",  32'(cnt), 32'd1);
        tick();
        #1 chk("bp_cnt0",  32'(cnt), 32'd0);

        // --- empty pop is ignored, pointers stay consistent ---
        tick(); iv = 1'b1; id = 16'h11;
        tick(); iv = 1'b0;
        #1 chk("ep_od", 32'(od), 32'h11);
        tick();

        // --- flush while full, concurrent beat 0xD dropped ---
        ordy = 1'b0; iv = 1'b1; id = 16'h1;
        tick(); id = 16'h2;
        tick(); flush = 1'b1; id = 16'hD;
        #1 chk("fl_pre_cnt", 32'(cnt), 32'd2);
        tick(); flush = 1'b0; iv = 1'b0;
        #1 chk("fl_cnt", 32'(cnt), 32'd0);
        chk("fl_ov",  32'(ov),  32'd0);
        chk("fl_od",  32'(od),  32'(RV));
        tick();
        #1 chk("fl_no_d", 32'(cnt), 32'd0);

        // --- flush with out_ready=1 and one entry: pop not counted, beat dropped ---
        ordy = 1'b1; iv = 1'b1; id = 16'h21;
        tick(); flush = 1'b1; id = 16'h22;
        tick(); flush = 1'b0; iv = 1'b0;
        #1 chk("fl2_cnt", 32'(cnt), 32'd0);
        chk("fl2_od",  32'(od),  32'(RV));
        tick();

        // --- reset with count=2 and flush=1; a beat during reset is dropped ---
        ordy = 1'b0; iv = 1'b1; id = 16'h5;
        tick(); id = 16'h6;
        tick(); rst_n = 1'b0; flush = 1'b1; id = 16'h99;
        #1 chk("rs_pre_cnt", 32'(cnt), 32'd2);
        tick(); rst_n = 1'b1; flush = 1'b0; id = 16'h7;
        #1 chk("rs_cnt", 32'(cnt), 32'd0);
        chk("rs_od",  32'(od),  32'(RV));
        tick(); iv = 1'b0;
        #1 chk("rs_push_cnt", 32'(cnt), 32'd1);
        chk("rs_push_od",  32'(od),  32'h7);
        ordy = 1'b1;
        tick();
        #1 chk("rs_drain", 32'(cnt), 32'd0);

        // --- DEPTH=3 interleaved traffic against a queue model ---
        iv_pat = 16'b1101_1011_0111_0110;
        or_pat = 16'b0010_1101_0011_1001;
        mcount = 0; pushes = 0; pops = 0; cyc = 0;
        while ((pops < 7) && (cyc < 60)) begin
            iv3   = (pushes < 7) && iv_pat[cyc % 16];
            id3   = 16'h100 + 16'(pushes);
            ordy3 = or_pat[cyc % 16];
            #1;
            m_push = iv3 && ((mcount < 3) || ordy3);
            m_pop  = (mcount != 0) && ordy3;
            chk("d3_cnt",  32'(cnt3),  32'(mcount));
            chk("d3_irdy", 32'(irdy3), 32'((mcount < 3) || ordy3));
            if (mcount != 0) chk("d3_head", 32'(od3), 32'(q[0]));
            else             chk("d3_bubble", 32'(od3), 32'(RV));
            if (m_pop) begin
                void'(q.pop_front());
                pops++;
                mcount--;
            end
            if (m_push) begin
                q.push_back(id3);
                pushes++;
                mcount++;
            end
            cyc++;
            tick();
        end
        chk("d3_done", 32'(pops), 32'd7);
        iv3 = 1'b0; ordy3 = 1'b0;
        #1 chk("d3_final_cnt", 32'(cnt3), 32'd0);

`ifdef PIPE_STAGE_BUF_PERF_EN
        // --- performance counters: 5 blocked cycles, 2 flush cycles, 6 full cycles ---
        rst_n = 1'b0; iv = 1'b0; ordy = 1'b0; flush = 1'b0;
        tick(); rst_n = 1'b1;
        #1 chk("pf_rst_stall", stall_cnt, 32'd0);
        iv = 1'b1; id = 16'h1;
        tick(); id = 16'h2;
        tick(); id = 16'h3;
        repeat (5) tick();
        iv = 1'b0; flush = 1'b1;
        tick(); tick(); flush = 1'b0;
        #1 chk("pf_stall", stall_cnt, 32'd5);
        chk("pf_flush", 32'(flush_cnt), 32'd2);
        chk("pf_full",  full_cnt, 32'd6);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
